pattern_gen: RTL

Transmit-side counter-pattern generator for the XCVR lane loopback/link test. It sits between the UART control block and the XCVR TX PCS fabric interface. On start it drives K28.5 comma words for lane alignment, then an incrementing 32-bit counter that the receive-side pattern checker locks to and compares. On request it injects single-bit errors so the bench can exercise the checker's error counting.

---
 rtl/pattern_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pattern_gen.sv
// Transmit-side counter-pattern generator for XCVR lane loopback: K28.5 comma
// alignment run, then an incrementing 32-bit counter with optional single-bit error injection.
module pattern_gen #(
  parameter int g_DATA_WID    = 32,
  parameter int g_ALIGN_WORDS = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  tx_ready_i,
  input  logic                  start_i,
  input  logic                  generate_err,
  output logic [g_DATA_WID-1:0] data_out_o,
  output logic [3:0]            tx_k_char_o,
  output logic                  tx_val_o,
  output logic [15:0]           err_inj_count_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ALIGN  = 2'b01,
    ST_DATA   = 2'b10,
    ST_UNUSED = 2'b11
  } state_t;

  localparam logic [g_DATA_WID-1:0] COMMA      = g_DATA_WID'(8'hBC);
  localparam logic [3:0]            K_COMMA    = 4'b0001;
  localparam logic [7:0]            ALIGN_LAST = 8'(g_ALIGN_WORDS - 1);

  state_t                  state;
  logic [g_DATA_WID-1:0]   cnt;
  logic [7:0]              align_cnt;
  logic                    err_pend;
  logic                    start_d1, start_d2;
  logic                    err_d1, err_d2, err_d3;
  logic                    err_rise;
  logic                    link_ok;
  logic [g_DATA_WID-1:0]   data_word;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [g_DATA_WID-1:0] inject_err(input logic [g_DATA_WID-1:0] w,
                                                       input logic en);
    return en ? (w ^ g_DATA_WID'(1)) : w;
  endfunction

  assign err_rise = err_d2 & ~err_d3;
  assign link_ok  = start_d2 & tx_ready_i;
  assign state_o  = state;

  // Word about to be driven: first data word after ALIGN is 1, otherwise the counter advances.
  always_comb begin
    data_word = g_DATA_WID'(1);
    if (state == ST_DATA) data_word = cnt + g_DATA_WID'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      start_d1        <= 1'b0;
      start_d2        <= 1'b0;
      err_d1          <= 1'b0;
      err_d2          <= 1'b0;
      err_d3          <= 1'b0;
      state           <= ST_IDLE;
      cnt             <= '0;
      align_cnt       <= '0;
      err_pend        <= 1'b0;
      data_out_o      <= '0;
      tx_k_char_o     <= 4'b0000;
      tx_val_o        <= 1'b0;
      err_inj_count_o <= 16'h0000;
    end else begin
      start_d1 <= start_i;
      start_d2 <= start_d1;
      err_d1   <= generate_err;
      err_d2   <= err_d1;
      err_d3   <= err_d2;

      data_out_o  <= COMMA;
      tx_k_char_o <= K_COMMA;
      tx_val_o    <= 1'b0;
      if (err_rise) err_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (link_ok) begin
            state     <= ST_ALIGN;
            align_cnt <= '0;
          end
        end
        ST_ALIGN, ST_DATA: begin
          if (!link_ok) begin
            // Losing start or TX ready abandons the stream, including any pending error.
            state     <= ST_IDLE;
            cnt       <= '0;
            align_cnt <= '0;
            err_pend  <= 1'b0;
          end else if (state == ST_ALIGN && align_cnt != ALIGN_LAST) begin
            align_cnt <= align_cnt + 8'd1;
          end else begin
            state       <= ST_DATA;
            cnt         <= data_word;
            data_out_o  <= inject_err(data_word, err_pend);
            tx_k_char_o <= 4'b0000;
            tx_val_o    <= 1'b1;
            if (err_pend) begin
              err_pend        <= err_rise;
              err_inj_count_o <= sat_inc(err_inj_count_o);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          align_cnt <= '0;
        end
      endcase
    end
  end

endmodule
